// File: rtl/mem_if_pkg.sv
// Shared definitions for the 16x32 single-port memory interface.
// Used by the burst initiator, the memory model and the test environment.
package mem_if_pkg;

  localparam int MEM_AW = 4;
  localparam int MEM_DW = 32;
  localparam int MEM_LW = 4;

  typedef enum logic [2:0] {
    IDLE,
    WR_BEAT,
    RD_ISSUE,
    RD_CAPT,
    RD_HOLD
  } mib_state_t;

endpackage

// File: rtl/burst_addr_ctr.sv
// Burst address / remaining-beat counter for mem_burst_initiator.
// Loads the start address and beats-1, then advances one beat per step.
module burst_addr_ctr
  import mem_if_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int LW = MEM_LW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          load_i,
  input  logic          step_i,
  input  logic [AW-1:0] addr_i,
  input  logic [LW-1:0] len_i,
  output logic [AW-1:0] cur_addr_o,
  output logic          last_o
);

  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [LW-1:0] LEN_ONE  = LW'(1);

  logic [AW-1:0] cur_addr_q, cur_addr_d;
  logic [LW-1:0] beats_left_q, beats_left_d;

  // Address increments modulo 2**AW so a burst may wrap past the top word.
  always_comb begin
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    if (load_i) begin
      cur_addr_d   = addr_i;
      beats_left_d = len_i;
    end else if (step_i) begin
      cur_addr_d   = cur_addr_q + ADDR_ONE;
      beats_left_d = beats_left_q - LEN_ONE;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cur_addr_q   <= '0;
      beats_left_q <= '0;
    end else begin
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
    end
  end

  assign cur_addr_o = cur_addr_q;
  assign last_o     = (beats_left_q == '0);

endmodule

// File: rtl/mem_burst_initiator.sv
// Burst initiator for the 16x32 single-port memory: one beat at a time,
// write data in and read data out over valid/ready handshakes.
//
// state    | meaning
// IDLE     | waiting for a command, cmd_ready high
// WR_BEAT  | one write beat per accepted wr_valid
// RD_ISSUE | memory read enable for one cycle
// RD_CAPT  | memory Data_Out valid, captured into rd_data
// RD_HOLD  | read beat presented until rd_ready
module mem_burst_initiator
  import mem_if_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW,
  parameter int LW = MEM_LW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [LW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          busy,
  output logic          done,
  output logic          rd_err,
  output logic          mem_en,
  output logic          mem_w_r,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_valid
);

  mib_state_t    state_q;
  logic [DW-1:0] rd_data_q;
  logic          rd_err_q;
  logic          done_q;

  logic          ctr_load;
  logic          ctr_step;
  logic          last;
  logic [AW-1:0] cur_addr;

  burst_addr_ctr #(
    .AW(AW),
    .LW(LW)
  ) u_ctr (
    .CLK       (CLK),
    .RST       (RST),
    .load_i    (ctr_load),
    .step_i    (ctr_step),
    .addr_i    (cmd_addr),
    .len_i     (cmd_len),
    .cur_addr_o(cur_addr),
    .last_o    (last)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            rd_err_q <= 1'b0;
            state_q  <= cmd_write ? WR_BEAT : RD_ISSUE;
          end
        end
        WR_BEAT: begin
          if (wr_valid && last) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        RD_ISSUE: state_q <= RD_CAPT;
        RD_CAPT: begin
          // mem_valid is sticky after the first read, so a low value means stale data.
          rd_data_q <= mem_rdata;
          rd_err_q  <= rd_err_q | ~mem_valid;
          state_q   <= RD_HOLD;
        end
        RD_HOLD: begin
          if (rd_ready) begin
            state_q <= last ? IDLE : RD_ISSUE;
            done_q  <= last;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    wr_ready  = (state_q == WR_BEAT);
    rd_valid  = (state_q == RD_HOLD);
    rd_last   = (state_q == RD_HOLD) && last;
    rd_data   = rd_data_q;
    rd_err    = rd_err_q;
    done      = done_q;
    mem_en    = ((state_q == WR_BEAT) && wr_valid) || (state_q == RD_ISSUE);
    mem_w_r   = (state_q == WR_BEAT);
    mem_addr  = cur_addr;
    mem_wdata = wr_data;
    ctr_load  = (state_q == IDLE) && cmd_valid;
    ctr_step  = (((state_q == WR_BEAT) && wr_valid) ||
                 ((state_q == RD_HOLD) && rd_ready)) && !last;
  end

endmodule

// File: tb/tb_mem_burst_initiator.sv
// Directed bench for mem_burst_initiator with a registered 16x32 memory model
// and a queue of expected read beats filled when each read command is issued.
module tb_mem_burst_initiator;
  import mem_if_pkg::*;

  logic                CLK = 1'b0;
  logic                RST = 1'b0;
  logic                cmd_valid = 1'b0;
  logic                cmd_ready;
  logic                cmd_write = 1'b0;
  logic [MEM_AW-1:0]   cmd_addr = '0;
  logic [MEM_LW-1:0]   cmd_len = '0;
  logic                wr_valid = 1'b0;
  logic                wr_ready;
  logic [MEM_DW-1:0]   wr_data = '0;
  logic                rd_valid;
  logic                rd_ready = 1'b0;
  logic [MEM_DW-1:0]   rd_data;
  logic                rd_last;
  logic                busy;
  logic                done;
  logic                rd_err;
  logic                mem_en;
  logic                mem_w_r;
  logic [MEM_AW-1:0]   mem_addr;
  logic [MEM_DW-1:0]   mem_wdata;
  logic [MEM_DW-1:0]   mem_rdata;
  logic                mem_valid;

  int n_pass  = 0;
  int n_total = 0;

  logic [MEM_DW-1:0] ref_mem [16];
  logic [MEM_DW-1:0] exp_q [$];

  mem_burst_initiator dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .done(done), .rd_err(rd_err),
    .mem_en(mem_en), .mem_w_r(mem_w_r), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid)
  );

  always #5 CLK = ~CLK;

  // Memory model: Data_Out registered on a read, Valid_Out rises one cycle after the first read.
  logic [MEM_DW-1:0] mem_arr [16];
  logic              rd_seen;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < 16; k++) mem_arr[k] <= '0;
      mem_rdata <= '0;
      mem_valid <= 1'b0;
      rd_seen   <= 1'b0;
    end else begin
      mem_valid <= rd_seen;
      if (mem_en) begin
        if (mem_w_r) mem_arr[mem_addr] <= mem_wdata;
        else begin
          mem_rdata <= mem_arr[mem_addr];
          rd_seen   <= 1'b1;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  task automatic send_cmd(input logic w, input logic [3:0] a, input logic [3:0] l);
    int t;
    t = 0;
    @(negedge CLK);
    while (!cmd_ready && t < 50) begin
      @(negedge CLK);
      t++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    @(negedge CLK);
    cmd_valid = 1'b0;
    chk("cmd_rd_err_clear", rd_err, 0);
    chk("cmd_busy", busy, 1);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [3:0] l,
                          input logic [31:0] base, input int gap_at);
    logic [3:0] ea;
    int dones;
    dones = 0;
    send_cmd(1'b1, a, l);
    for (int i = 0; i <= int'(l); i++) begin
      ea = a + 4'(i);
      if (i == gap_at) begin
        wr_valid = 1'b0;
        repeat (2) begin
          #1;
          chk("wr_gap_mem_en", mem_en, 0);
          chk("wr_gap_addr", mem_addr, ea);
          @(negedge CLK);
        end
      end
      wr_valid = 1'b1;
      wr_data  = base + 32'(i);
      #1;
      chk("wr_mem_en", mem_en, 1);
      chk("wr_mem_w_r", mem_w_r, 1);
      chk("wr_mem_addr", mem_addr, ea);
      chk("wr_mem_wdata", mem_wdata, base + 32'(i));
      ref_mem[ea] = base + 32'(i);
      @(negedge CLK);
      if (done) dones++;
    end
    wr_valid = 1'b0;
    #1;
    chk("wr_done_count", dones, 1);
    chk("wr_back_idle", cmd_ready, 1);
    @(negedge CLK);
    #1;
    chk("wr_done_single", done, 0);
  endtask

  task automatic do_read(input logic [3:0] a, input logic [3:0] l,
                         input int stall_beat, input logic exp_err);
    logic [3:0]  ea;
    logic [31:0] ev;
    int lat;
    int dones;
    for (int i = 0; i <= int'(l); i++) begin
      ea = a + 4'(i);
      exp_q.push_back(ref_mem[ea]);
    end
    send_cmd(1'b0, a, l);
    dones = 0;
    for (int i = 0; i <= int'(l); i++) begin
      ea = a + 4'(i);
      #1;
      chk("rd_issue_en", mem_en, 1);
      chk("rd_issue_w_r", mem_w_r, 0);
      chk("rd_issue_addr", mem_addr, ea);
      lat = 0;
      while (lat < 8) begin
        @(negedge CLK);
        lat++;
        #1;
        if (rd_valid) break;
        chk("rd_capt_en", mem_en, 0);
      end
      chk("rd_latency", lat, 2);
      if (i == stall_beat) begin
        repeat (5) begin
          chk("rd_stall_valid", rd_valid, 1);
          chk("rd_stall_data", rd_data, exp_q[0]);
          chk("rd_stall_en", mem_en, 0);
          @(negedge CLK);
          #1;
        end
      end
      rd_ready = 1'b1;
      ev = exp_q.pop_front();
      chk("rd_data", rd_data, ev);
      chk("rd_last", rd_last, (i == int'(l)));
      chk("rd_err", rd_err, exp_err);
      @(negedge CLK);
      rd_ready = 1'b0;
      if (done) dones++;
    end
    #1;
    chk("rd_done_count", dones, 1);
    chk("rd_back_idle", busy, 0);
    chk("rd_sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    int dones;
    for (int k = 0; k < 16; k++) ref_mem[k] = '0;

    repeat (3) @(negedge CLK);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_last", rd_last, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_err", rd_err, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_w_r", mem_w_r, 0);
    chk("rst_mem_addr", mem_addr, 0);
    RST = 1'b1;

    // first read after reset sees mem_valid low
    do_read(4'd0, 4'd0, -1, 1'b1);
    chk("rd_err_sticky_idle", rd_err, 1);

    do_write(4'd3, 4'd3, 32'hA0, -1);
    do_read(4'd3, 4'd3, -1, 1'b0);

    do_write(4'd14, 4'd2, 32'hB0, -1);
    do_read(4'd14, 4'd2, -1, 1'b0);

    do_write(4'd8, 4'd5, 32'hC0, 2);
    do_read(4'd8, 4'd5, 3, 1'b0);

    // reset in the middle of an 8-beat write, after three beats
    send_cmd(1'b1, 4'd0, 4'd7);
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1;
      wr_data  = 32'hD0 + 32'(i);
      @(negedge CLK);
    end
    wr_data = 32'hD3;
    RST = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr_ready", wr_ready, 0);
    chk("mid_rst_mem_en", mem_en, 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_rd_data", rd_data, 0);
    chk("mid_rst_done", done, 0);
    wr_valid = 1'b0;
    dones = 0;
    repeat (2) begin
      @(negedge CLK);
      if (done) dones++;
    end
    RST = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      if (done) dones++;
    end
    #1;
    chk("mid_rst_no_done", dones, 0);
    chk("mid_rst_release_ready", cmd_ready, 1);
    chk("mid_rst_release_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
